// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, reads instruction memory, and feeds decode.
// It has a one-entry skid buffer for decode stalls and a flush path for redirects.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h4000_0060,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_address_o,
    output logic        imem_read_o,
    input  logic [31:0] imem_rdata_i,
    input  logic        imem_resp_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] fetched_instruction_o,
    output logic [31:0] PC_val_o,
    output logic        valid_o
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_DRAIN = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_run;
    logic [31:0] r_pc;
    logic [31:0] r_target;
    logic [31:0] r_out_instr;
    logic [31:0] r_out_pc;
    logic        r_valid;
    logic [31:0] r_skid_instr;
    logic [31:0] r_skid_pc;

    logic [31:0] w_pc_nxt;
    logic [31:0] w_target_nxt;
    logic [31:0] w_out_instr_nxt;
    logic [31:0] w_out_pc_nxt;
    logic        w_valid_nxt;
    logic [31:0] w_skid_instr_nxt;
    logic [31:0] w_skid_pc_nxt;

    logic [31:0] w_tgt;
    logic [31:0] w_pc_inc;
    logic        w_can_load;

    assign w_tgt      = redirect_pc_i & 32'hFFFF_FFFC;
    assign w_pc_inc   = r_pc + 32'd4;
    assign w_can_load = !r_valid || !stall_i;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FETCH: begin
                if (redirect_i) begin
                    if (!imem_resp_i) begin
                        w_state_nxt = S_FLUSH;
                    end
                end else if (imem_resp_i && !w_can_load) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (redirect_i || !stall_i) begin
                    w_state_nxt = S_FETCH;
                end
            end
            S_FLUSH: begin
                if (imem_resp_i) begin
                    w_state_nxt = S_FETCH;
                end
            end
            default: w_state_nxt = S_FETCH;
        endcase
    end

    // r_run keeps the read request low for as long as reset is held.
    always_comb begin
        imem_read_o    = r_run && (r_state != S_DRAIN);
        imem_address_o = r_pc;
    end

    assign fetched_instruction_o = r_out_instr;
    assign PC_val_o              = r_out_pc;
    assign valid_o               = r_valid;

    always_comb begin
        w_pc_nxt         = r_pc;
        w_target_nxt     = r_target;
        w_out_instr_nxt  = r_out_instr;
        w_out_pc_nxt     = r_out_pc;
        w_valid_nxt      = r_valid;
        w_skid_instr_nxt = r_skid_instr;
        w_skid_pc_nxt    = r_skid_pc;

        if (redirect_i) begin
            w_valid_nxt     = 1'b0;
            w_out_instr_nxt = NOP_INSTR;
            // An outstanding read cannot be aborted, so park the target.
            if (r_state == S_DRAIN || imem_resp_i) begin
                w_pc_nxt = w_tgt;
            end else begin
                w_target_nxt = w_tgt;
            end
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_resp_i) begin
                        w_pc_nxt = w_pc_inc;
                        if (w_can_load) begin
                            w_out_instr_nxt = imem_rdata_i;
                            w_out_pc_nxt    = r_pc;
                            w_valid_nxt     = 1'b1;
                        end else begin
                            w_skid_instr_nxt = imem_rdata_i;
                            w_skid_pc_nxt    = r_pc;
                        end
                    end else if (r_valid && !stall_i) begin
                        w_valid_nxt     = 1'b0;
                        w_out_instr_nxt = NOP_INSTR;
                    end
                end
                S_DRAIN: begin
                    if (!stall_i) begin
                        w_out_instr_nxt = r_skid_instr;
                        w_out_pc_nxt    = r_skid_pc;
                        w_valid_nxt     = 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (imem_resp_i) begin
                        w_pc_nxt = r_target;
                    end
                end
                default: begin
                    w_valid_nxt     = 1'b0;
                    w_out_instr_nxt = NOP_INSTR;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_run        <= 1'b0;
            r_pc         <= RESET_PC;
            r_target     <= RESET_PC;
            r_out_instr  <= NOP_INSTR;
            r_out_pc     <= RESET_PC;
            r_valid      <= 1'b0;
            r_skid_instr <= NOP_INSTR;
            r_skid_pc    <= RESET_PC;
        end else begin
            r_run        <= 1'b1;
            r_pc         <= w_pc_nxt;
            r_target     <= w_target_nxt;
            r_out_instr  <= w_out_instr_nxt;
            r_out_pc     <= w_out_pc_nxt;
            r_valid      <= w_valid_nxt;
            r_skid_instr <= w_skid_instr_nxt;
            r_skid_pc    <= w_skid_pc_nxt;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: normal fetch, stall/skid, redirects, PC wrap, reset.
// Inputs change and outputs are sampled on the falling edge of the clock.
module tb_fetch_stage;

    localparam logic [31:0] RPC = 32'h4000_0060;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] imem_address_o;
    logic        imem_read_o;
    logic [31:0] imem_rdata_i = '0;
    logic        imem_resp_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic [31:0] fetched_instruction_o;
    logic [31:0] PC_val_o;
    logic        valid_o;

    int n_cmp = 0;
    int n_bad = 0;

    fetch_stage dut (
        .clk                   (clk),
        .rst                   (rst),
        .imem_address_o        (imem_address_o),
        .imem_read_o           (imem_read_o),
        .imem_rdata_i          (imem_rdata_i),
        .imem_resp_i           (imem_resp_i),
        .stall_i               (stall_i),
        .redirect_i            (redirect_i),
        .redirect_pc_i         (redirect_pc_i),
        .fetched_instruction_o (fetched_instruction_o),
        .PC_val_o              (PC_val_o),
        .valid_o               (valid_o)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v,
                           input logic [31:0] ins, input logic [31:0] pc);
        chk({tag, ".valid"}, {31'd0, valid_o}, {31'd0, v});
        chk({tag, ".instr"}, fetched_instruction_o, ins);
        chk({tag, ".pc"}, PC_val_o, pc);
    endtask

    task automatic chk_rd(input string tag, input logic rd,
                          input logic [31:0] a);
        chk({tag, ".read"}, {31'd0, imem_read_o}, {31'd0, rd});
        chk({tag, ".addr"}, imem_address_o, a);
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic give(input logic [31:0] d);
        imem_resp_i  = 1'b1;
        imem_rdata_i = d;
    endtask

    initial begin
        #1 rst = 1'b1;
        cyc();
        cyc();
        chk_out("rst", 1'b0, NOP, RPC);
        chk_rd("rst", 1'b0, RPC);
        rst = 1'b0;

        // Normal fetch, response every second cycle
        cyc();
        chk_rd("t1.a", 1'b1, RPC);
        chk_out("t1.a", 1'b0, NOP, RPC);
        give(dat(RPC));
        cyc();
        imem_resp_i = 1'b0;
        chk_out("t1.b", 1'b1, dat(RPC), RPC);
        chk_rd("t1.b", 1'b1, RPC + 4);
        cyc();
        chk_out("t1.c", 1'b0, NOP, RPC);
        chk_rd("t1.c", 1'b1, RPC + 4);
        give(dat(RPC + 4));
        cyc();
        imem_resp_i = 1'b0;
        chk_out("t1.d", 1'b1, dat(RPC + 4), RPC + 4);
        chk_rd("t1.d", 1'b1, RPC + 8);
        cyc();
        chk_rd("t1.e", 1'b1, RPC + 8);
        give(dat(RPC + 8));
        cyc();
        imem_resp_i = 1'b0;
        chk_out("t1.f", 1'b1, dat(RPC + 8), RPC + 8);
        chk_rd("t1.f", 1'b1, RPC + 12);

        // Stall with valid output, response lands in skid
        stall_i = 1'b1;
        cyc();
        chk_out("t2.a", 1'b1, dat(RPC + 8), RPC + 8);
        cyc();
        cyc();
        chk_out("t2.b", 1'b1, dat(RPC + 8), RPC + 8);
        chk_rd("t2.b", 1'b1, RPC + 12);
        give(dat(RPC + 12));
        cyc();
        imem_resp_i = 1'b0;
        chk_out("t2.c", 1'b1, dat(RPC + 8), RPC + 8);
        chk_rd("t2.c", 1'b0, RPC + 16);
        cyc();
        chk_out("t2.d", 1'b1, dat(RPC + 8), RPC + 8);
        chk_rd("t2.d", 1'b0, RPC + 16);
        stall_i = 1'b0;
        cyc();
        chk_out("t2.e", 1'b1, dat(RPC + 12), RPC + 12);
        chk_rd("t2.e", 1'b1, RPC + 16);

        // Redirect while a read is outstanding
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h4000_0103;
        cyc();
        redirect_i = 1'b0;
        chk_out("t3.a", 1'b0, NOP, RPC + 12);
        chk_rd("t3.a", 1'b1, RPC + 16);
        give(dat(RPC + 16));
        cyc();
        imem_resp_i = 1'b0;
        chk({"t3.b", ".valid"}, {31'd0, valid_o}, 32'd0);
        chk({"t3.b", ".instr"}, fetched_instruction_o, NOP);
        chk_rd("t3.b", 1'b1, 32'h4000_0100);

        // Redirect in the same cycle as a response
        give(32'hDEAD_BEEF);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h4000_0200;
        cyc();
        imem_resp_i = 1'b0;
        redirect_i  = 1'b0;
        chk({"t4.a", ".valid"}, {31'd0, valid_o}, 32'd0);
        chk({"t4.a", ".instr"}, fetched_instruction_o, NOP);
        chk_rd("t4.a", 1'b1, 32'h4000_0200);
        cyc();
        chk({"t4.b", ".valid"}, {31'd0, valid_o}, 32'd0);

        // Two redirects inside one flush; the latest target wins
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h0000_1000;
        cyc();
        redirect_pc_i = 32'h0000_2000;
        chk_rd("t5.a", 1'b1, 32'h4000_0200);
        cyc();
        redirect_i = 1'b0;
        chk_rd("t5.b", 1'b1, 32'h4000_0200);
        give(32'hBAD0_0001);
        cyc();
        imem_resp_i = 1'b0;
        chk_rd("t5.c", 1'b1, 32'h0000_2000);
        chk({"t5.c", ".valid"}, {31'd0, valid_o}, 32'd0);
        give(dat(32'h0000_2000));
        cyc();
        imem_resp_i = 1'b0;
        chk_out("t5.d", 1'b1, dat(32'h0000_2000), 32'h0000_2000);
        chk_rd("t5.d", 1'b1, 32'h0000_2004);

        // PC wrap at the top of the address space
        give(32'hBAD0_0002);
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFF;
        cyc();
        imem_resp_i = 1'b0;
        redirect_i  = 1'b0;
        chk_rd("t6.a", 1'b1, 32'hFFFF_FFFC);
        give(dat(32'hFFFF_FFFC));
        cyc();
        imem_resp_i = 1'b0;
        chk_out("t6.b", 1'b1, dat(32'hFFFF_FFFC), 32'hFFFF_FFFC);
        chk_rd("t6.b", 1'b1, 32'h0000_0000);

        // Reset pulse mid-request, with a late response during reset
        rst = 1'b1;
        #1;
        chk_out("t6.c", 1'b0, NOP, RPC);
        chk_rd("t6.c", 1'b0, RPC);
        give(32'hBAD0_0003);
        cyc();
        imem_resp_i = 1'b0;
        chk_out("t6.d", 1'b0, NOP, RPC);
        rst = 1'b0;
        cyc();
        chk_rd("t6.e", 1'b1, RPC);
        chk_out("t6.e", 1'b0, NOP, RPC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
